// File: rtl/bcd_counter_4dig_pkg.sv
// Shared constants and helpers for the four-digit BCD up/down counter.
package bcd_counter_4dig_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_MIN = 4'd0;
  localparam int unsigned PRESC_W = 24;

  // A nibble that is not a legal decimal digit loads as zero.
  function automatic logic [3:0] bcd_sanitize(input logic [3:0] nib);
    logic [3:0] res;
    if (nib > BCD_MAX) begin
      res = BCD_MIN;
    end else begin
      res = nib;
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_counter_4dig_digit.sv
// One BCD decade with load, up/down stepping and a ripple carry/borrow out.
module bcd_digit
  import bcd_counter_4dig_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       up,
  input  logic       en_in,
  input  logic       load,
  input  logic [3:0] load_val,
  output logic [3:0] dig,
  output logic       carry_out
);

  logic [3:0] dig_r;
  logic [3:0] dig_nxt_s;

  // Carry/borrow only propagates when this decade is actually stepping past its limit.
  assign carry_out = en_in & (up ? (dig_r == BCD_MAX) : (dig_r == BCD_MIN));
  assign dig       = dig_r;

  // Next-digit selection: load wins over stepping.
  always_comb begin
    dig_nxt_s = dig_r;
    if (load) begin
      dig_nxt_s = bcd_sanitize(load_val);
    end else if (en_in) begin
      if (up) begin
        dig_nxt_s = (dig_r >= BCD_MAX) ? BCD_MIN : dig_r + 4'd1;
      end else begin
        dig_nxt_s = (dig_r == BCD_MIN || dig_r > BCD_MAX) ? BCD_MAX : dig_r - 4'd1;
      end
    end else begin
      dig_nxt_s = dig_r;
    end
  end

  // Digit register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dig_r <= BCD_MIN;
    end else begin
      dig_r <= dig_nxt_s;
    end
  end

endmodule

// File: rtl/bcd_counter_4dig.sv
// Four-digit BCD up/down counter with prescaler, load, clear, wrap pulse and blink output.
module bcd_counter_4dig
  import bcd_counter_4dig_pkg::*;
#(
  parameter logic [23:0] PRESCALE = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic        i_up,
  input  logic        i_clear,
  input  logic        i_load,
  input  logic [15:0] i16_load_val,
  output logic [3:0]  o4_dig1,
  output logic [3:0]  o4_dig2,
  output logic [3:0]  o4_dig3,
  output logic [3:0]  o4_dig4,
  output logic        o_carry,
  output logic        o_twopoint
);

  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESCALE - 24'd1;

  logic [PRESC_W-1:0] presc_r;
  logic               tick_s;
  logic               apply_s;
  logic               dig_load_s;
  logic [3:0]         en_chain_s;
  logic [3:0]         carry_chain_s;
  logic [3:0]         dig_s [4];
  logic               carry_r;
  logic               twopoint_r;

  assign tick_s     = i_en & (presc_r == PRESC_LAST);
  // Clear and load both pre-empt a coincident tick; clear rides the load path with zeros.
  assign apply_s    = tick_s & ~i_clear & ~i_load;
  assign dig_load_s = i_clear | i_load;

  // Prescaler: clear zeroes it, otherwise it runs only while enabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_r <= '0;
    end else if (i_clear) begin
      presc_r <= '0;
    end else if (i_en) begin
      presc_r <= (presc_r == PRESC_LAST) ? '0 : presc_r + 24'd1;
    end else begin
      presc_r <= presc_r;
    end
  end

  genvar k;
  generate
    for (k = 0; k < 4; k++) begin : g_dig
      if (k == 0) begin : g_first
        assign en_chain_s[k] = apply_s;
      end else begin : g_rest
        assign en_chain_s[k] = carry_chain_s[k-1];
      end
      bcd_digit u_digit (
        .clk      (clk),
        .rst      (rst),
        .up       (i_up),
        .en_in    (en_chain_s[k]),
        .load     (dig_load_s),
        .load_val (i_clear ? 4'd0 : i16_load_val[4*k +: 4]),
        .dig      (dig_s[k]),
        .carry_out(carry_chain_s[k])
      );
    end
  endgenerate

  // Wrap pulse and blink indicator registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_r    <= 1'b0;
      twopoint_r <= 1'b0;
    end else begin
      carry_r    <= carry_chain_s[3];
      twopoint_r <= twopoint_r ^ apply_s;
    end
  end

  assign o4_dig1    = dig_s[0];
  assign o4_dig2    = dig_s[1];
  assign o4_dig3    = dig_s[2];
  assign o4_dig4    = dig_s[3];
  assign o_carry    = carry_r;
  assign o_twopoint = twopoint_r;

endmodule

// File: tb/tb_bcd_counter_4dig.sv
// Self-checking bench: load table, directed corner sequences and randomized run against an integer model.
module tb_bcd_counter_4dig;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0, up = 1'b1, clear = 1'b0, load = 1'b0;
  logic [15:0] load_val = 16'h0000;
  logic [3:0]  d1, d2, d3, d4;
  logic        carry, tp;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: counter as a plain integer 0..9999.
  int   m_val = 0;
  int   m_presc = 0;
  logic m_carry = 1'b0;
  logic m_tp = 1'b0;

  bcd_counter_4dig #(.PRESCALE(24'd4)) dut (
    .clk(clk), .rst(rst), .i_en(en), .i_up(up), .i_clear(clear), .i_load(load),
    .i16_load_val(load_val), .o4_dig1(d1), .o4_dig2(d2), .o4_dig3(d3), .o4_dig4(d4),
    .o_carry(carry), .o_twopoint(tp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] x);
    int r = 0;
    for (int i = 3; i >= 0; i--) begin
      logic [3:0] nib;
      nib = x[4*i +: 4];
      r = r * 10 + ((nib > 4'd9) ? 0 : int'(nib));
    end
    return r;
  endfunction

  function automatic logic [15:0] digits();
    return {d4, d3, d2, d1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_val = 0; m_presc = 0; m_carry = 1'b0; m_tp = 1'b0;
  endtask

  // One clock: advance the model from the sampled inputs, then compare everything.
  task automatic cyc();
    bit tick;
    @(posedge clk);
    tick = en && (m_presc == P - 1);
    if (rst) begin
      m_reset();
    end else if (clear) begin
      m_val = 0; m_presc = 0; m_carry = 1'b0;
    end else begin
      if (en) m_presc = (m_presc + 1) % P;
      if (load) begin
        m_val = from_load(load_val); m_carry = 1'b0;
      end else if (tick) begin
        if (up) begin
          m_carry = (m_val == 9999); m_val = (m_val + 1) % 10000;
        end else begin
          m_carry = (m_val == 0); m_val = (m_val + 9999) % 10000;
        end
        m_tp = ~m_tp;
      end else begin
        m_carry = 1'b0;
      end
    end
    #1;
    check("model", {14'd0, digits(), carry, tp}, {14'd0, to_bcd(m_val), m_carry, m_tp});
  endtask

  task automatic set_in(input logic e, input logic u, input logic c, input logic l, input logic [15:0] v);
    en = e; up = u; clear = c; load = l; load_val = v;
  endtask

  typedef struct {
    logic [15:0] val;
    logic [15:0] exp;
  } load_vec_t;

  load_vec_t ltab [7];

  initial begin
    ltab[0] = '{16'h1AF9, 16'h1009};
    ltab[1] = '{16'hFFFF, 16'h0000};
    ltab[2] = '{16'h9999, 16'h9999};
    ltab[3] = '{16'hA5B3, 16'h0503};
    ltab[4] = '{16'h1234, 16'h1234};
    ltab[5] = '{16'hC0DE, 16'h0000};
    ltab[6] = '{16'h0908, 16'h0908};

    // Reset state, before any clock edge.
    #2;
    check("reset_state", {14'd0, digits(), carry, tp}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_reset();

    // Count up from zero: value k/4 after k enabled cycles, blink follows the step parity.
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    for (int k = 1; k <= 40; k++) begin
      cyc();
      check("up_step", {16'd0, digits()}, {16'd0, to_bcd(k / P)});
      check("up_blink", {31'd0, tp}, {31'd0, 1'(((k / P) % 2))});
    end

    // Load table with illegal-nibble sanitising.
    foreach (ltab[i]) begin
      set_in(1'b0, 1'b1, 1'b0, 1'b1, ltab[i].val);
      cyc();
      check("load_tab", {16'd0, digits()}, {16'd0, ltab[i].exp});
    end

    // Up wrap 9998 -> 9999 -> 0000 with a single carry pulse.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 16'h9998); cyc();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (P) cyc();
    check("upwrap_9999", {15'd0, digits(), carry}, {15'd0, 16'h9999, 1'b0});
    repeat (P) cyc();
    check("upwrap_0000", {15'd0, digits(), carry}, {15'd0, 16'h0000, 1'b1});
    cyc();
    check("upwrap_pulse_end", {31'd0, carry}, 32'd0);

    // Down wrap 0001 -> 0000 -> 9999.
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000); cyc();
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 16'h0001); cyc();
    set_in(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (P) cyc();
    check("dnwrap_0000", {15'd0, digits(), carry}, {15'd0, 16'h0000, 1'b0});
    repeat (P) cyc();
    check("dnwrap_9999", {15'd0, digits(), carry}, {15'd0, 16'h9999, 1'b1});
    cyc();
    check("dnwrap_pulse_end", {31'd0, carry}, 32'd0);

    // Load 1AF9 then one up tick gives 1010.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 16'h1AF9); cyc();
    check("load_1af9", {16'd0, digits()}, 32'h1009);
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (P) cyc();
    check("tick_after_1af9", {16'd0, digits()}, 32'h1010);

    // Clear+load coincident with a tick, then load alone coincident with a tick.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 16'h0123); cyc();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (P - 1) cyc();
    begin
      logic tp_before;
      tp_before = tp;
      set_in(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234); cyc();
      check("clr_ld_tick", {14'd0, digits(), carry, tp}, {14'd0, 16'h0000, 1'b0, tp_before});
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (P - 1) cyc();
      tp_before = tp;
      set_in(1'b1, 1'b1, 1'b0, 1'b1, 16'h4321); cyc();
      check("ld_tick", {14'd0, digits(), carry, tp}, {14'd0, 16'h4321, 1'b0, tp_before});
      set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
      repeat (P) cyc();
      check("after_ld_tick", {16'd0, digits()}, 32'h4322);
    end

    // Asynchronous reset between edges at 0457, then restart timing.
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000); cyc();
    set_in(1'b0, 1'b1, 1'b0, 1'b1, 16'h0457); cyc();
    set_in(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    repeat (2) cyc();
    check("pre_rst_0457", {16'd0, digits()}, 32'h0457);
    #3 rst = 1'b1;
    #1;
    check("async_rst", {14'd0, digits(), carry, tp}, 32'd0);
    m_reset();
    #2 rst = 1'b0;
    repeat (P - 1) cyc();
    check("rst_hold", {15'd0, digits(), carry}, 32'd0);
    cyc();
    check("rst_first_step", {15'd0, digits(), carry}, {15'd0, 16'h0001, 1'b0});

    // Randomized run against the model.
    for (int n = 0; n < 600; n++) begin
      logic [15:0] v;
      case ($urandom_range(0, 4))
        0: v = 16'h9998;
        1: v = 16'h0001;
        2: v = 16'h9999;
        3: v = 16'h0000;
        default: v = 16'($urandom);
      endcase
      set_in($urandom_range(0, 9) != 0,
             ($urandom_range(0, 19) == 0) ? ~up : up,
             $urandom_range(0, 59) == 0,
             $urandom_range(0, 29) == 0,
             v);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
